// File: rtl/srdl2sv_ahb_pkg.sv
// Shared AHB-Lite types, bridge FSM state encoding and burst helpers for the
// srdl2sv AHB-Lite to register-bus bridge.
package srdl2sv_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } HTRANS_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } HBURST_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } HRESP_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DATA  = 2'b01,
    ST_ERR_0 = 2'b10,
    ST_ERR_1 = 2'b11
  } state_t;

  // Control captured with each accepted address phase
  typedef struct packed {
    logic       write;
    logic [2:0] size;
  } ahb_ctrl_t;

  // Beats per burst; undefined-length INCR reports 0
  function automatic logic [4:0] burst_beats(input HBURST_t burst);
    case (burst)
      HBURST_SINGLE:                 return 5'd1;
      HBURST_WRAP4,  HBURST_INCR4:   return 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:   return 5'd8;
      HBURST_WRAP16, HBURST_INCR16:  return 5'd16;
      default:                       return 5'd0;
    endcase
  endfunction

  function automatic logic is_wrap(input HBURST_t burst);
    return (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) || (burst == HBURST_WRAP16);
  endfunction

endpackage

// File: rtl/srdl2sv_ahb_addr_gen.sv
// Next expected burst address (INCR / WRAP) and register-bus byte-lane enables.
module srdl2sv_ahb_addr_gen
  import srdl2sv_ahb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]                 addr,
  input  logic [2:0]                        size,
  input  HBURST_t                           burst,
  output logic [ADDR_W-1:0]                 next_addr,
  input  logic [$clog2(DATA_W/8)-1:0]       lane,
  input  logic [2:0]                        lane_size,
  output logic [DATA_W/8-1:0]               byte_en
);

  localparam int unsigned NB = DATA_W / 8;

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] incr_addr;
  logic [NB-1:0]     ones;

  // Wrapping bursts keep the upper bits of the (beats << size)-byte window
  assign step      = ADDR_W'(1) << size;
  assign wrap_mask = (ADDR_W'(burst_beats(burst)) << size) - ADDR_W'(1);
  assign incr_addr = addr + step;
  assign next_addr = is_wrap(burst) ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                    : incr_addr;

  always_comb begin
    ones = '0;
    case (lane_size)
      3'd0:    ones = NB'(8'h01);
      3'd1:    ones = NB'(8'h03);
      3'd2:    ones = NB'(8'h0F);
      3'd3:    ones = NB'(8'hFF);
      default: ones = '0;
    endcase
  end

  assign byte_en = ones << lane;

endmodule

// File: rtl/srdl2sv_ahblite_bridge.sv
// AHB-Lite slave to srdl2sv register-bus bridge with burst checking and wait timeout.
// Define SRDL2SV_AHB_B2R_FLOP_EN to register the b2r_* outputs (one extra cycle per transfer).
module srdl2sv_ahblite_bridge
  import srdl2sv_ahb_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic [3:0]          HPROT,
  input  logic [1:0]          HTRANS,
  input  logic [DATA_W-1:0]   HWDATA,
  input  logic                HREADY,
  input  logic                HMASTLOCK,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [DATA_W-1:0]   HRDATA,
  output logic [ADDR_W-1:0]   b2r_addr,
  output logic [DATA_W-1:0]   b2r_data,
  output logic [DATA_W/8-1:0] b2r_byte_en,
  output logic                b2r_w_vld,
  output logic                b2r_r_vld,
  input  logic [DATA_W-1:0]   r2b_data,
  input  logic                r2b_rdy,
  input  logic                r2b_err
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned LANE_W  = $clog2(NB);
  localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t            state, next_state;
  HTRANS_t           trans;
  logic [ADDR_W-1:0] addr_q, exp_q, next_addr, align_mask;
  ahb_ctrl_t         ctrl_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [NB-1:0]     byte_en_c;
  logic              accept, legal, take, launched, counting, timed_out;
  logic              unused;

  assign unused = ^{HPROT, HMASTLOCK};
  assign trans  = HTRANS_t'(HTRANS);
  assign accept = HSEL && HREADY && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

  // Oversize, misaligned or off-sequence beats are answered with ERROR
  assign align_mask = (ADDR_W'(1) << HSIZE) - ADDR_W'(1);
  assign legal = !((HSIZE > 3'(LANE_W)) || (|(HADDR & align_mask)) ||
                   ((trans == HTRANS_SEQ) && (HADDR != exp_q)));

  srdl2sv_ahb_addr_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .addr      (HADDR),
    .size      (HSIZE),
    .burst     (HBURST_t'(HBURST)),
    .next_addr (next_addr),
    .lane      (addr_q[LANE_W-1:0]),
    .lane_size (ctrl_q.size),
    .byte_en   (byte_en_c)
  );

  assign counting  = launched && !r2b_rdy;
  assign timed_out = (TIMEOUT != 0) && counting && (wait_cnt == CNT_W'(TO_LAST));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    take       = 1'b0;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          take       = 1'b1;
          next_state = legal ? ST_DATA : ST_ERR_0;
        end
      end
      ST_DATA: begin
        // An erroring slave holds HREADYOUT low so the two-cycle ERROR follows
        HREADYOUT = launched && r2b_rdy && !r2b_err;
        if (timed_out || (launched && r2b_rdy && r2b_err)) begin
          next_state = ST_ERR_0;
        end else if (launched && r2b_rdy) begin
          if (accept) begin
            take       = 1'b1;
            next_state = legal ? ST_DATA : ST_ERR_0;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      ST_ERR_0: begin
        HREADYOUT  = 1'b0;
        HRESP      = HRESP_ERROR;
        next_state = ST_ERR_1;
      end
      ST_ERR_1: begin
        HRESP      = HRESP_ERROR;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Address-phase capture, burst tracking and wait counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q   <= '0;
      ctrl_q   <= '0;
      exp_q    <= '0;
      wait_cnt <= '0;
    end else if (take) begin
      addr_q   <= HADDR;
      ctrl_q   <= '{write: HWRITE, size: HSIZE};
      exp_q    <= next_addr;
      wait_cnt <= '0;
    end else if ((state == ST_DATA) && counting && (TIMEOUT != 0)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign HRDATA = ((state == ST_DATA) && !ctrl_q.write) ? r2b_data : '0;

`ifdef SRDL2SV_AHB_B2R_FLOP_EN
  logic stay;

  // Valids launch one cycle into the data phase and drop on completion
  assign stay     = (state == ST_DATA) && (next_state == ST_DATA) && !take;
  assign launched = b2r_w_vld || b2r_r_vld;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      b2r_w_vld   <= 1'b0;
      b2r_r_vld   <= 1'b0;
      b2r_addr    <= '0;
      b2r_data    <= '0;
      b2r_byte_en <= '0;
    end else begin
      b2r_w_vld   <= stay && ctrl_q.write;
      b2r_r_vld   <= stay && !ctrl_q.write;
      b2r_addr    <= addr_q;
      b2r_data    <= HWDATA;
      b2r_byte_en <= byte_en_c;
    end
  end
`else
  assign launched    = 1'b1;
  assign b2r_w_vld   = (state == ST_DATA) && ctrl_q.write;
  assign b2r_r_vld   = (state == ST_DATA) && !ctrl_q.write;
  assign b2r_addr    = addr_q;
  assign b2r_data    = HWDATA;
  assign b2r_byte_en = byte_en_c;
`endif

endmodule

// File: tb/tb_srdl2sv_ahblite_bridge.sv
// Directed bench for srdl2sv_ahblite_bridge: a 32-bit and a 64-bit instance, both TIMEOUT=4.
module tb_srdl2sv_ahblite_bridge;
  import srdl2sv_ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel32, sel64, hwrite, r2b_rdy, r2b_err;
  logic [31:0] haddr;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [63:0] hwdata, r2b_data;

  logic        ready32, resp32, wv32, rv32;
  logic [31:0] rdata32, addr32, data32;
  logic [3:0]  be32;
  logic        ready64, resp64, wv64, rv64;
  logic [63:0] rdata64, data64;
  logic [31:0] addr64;
  logic [7:0]  be64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  srdl2sv_ahblite_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel32), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(4'h0), .HTRANS(htrans),
    .HWDATA(hwdata[31:0]), .HREADY(ready32), .HMASTLOCK(1'b0),
    .HREADYOUT(ready32), .HRESP(resp32), .HRDATA(rdata32),
    .b2r_addr(addr32), .b2r_data(data32), .b2r_byte_en(be32),
    .b2r_w_vld(wv32), .b2r_r_vld(rv32),
    .r2b_data(r2b_data[31:0]), .r2b_rdy(r2b_rdy), .r2b_err(r2b_err));

  srdl2sv_ahblite_bridge #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) dut64 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel64), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HPROT(4'h0), .HTRANS(htrans),
    .HWDATA(hwdata), .HREADY(ready64), .HMASTLOCK(1'b0),
    .HREADYOUT(ready64), .HRESP(resp64), .HRDATA(rdata64),
    .b2r_addr(addr64), .b2r_data(data64), .b2r_byte_en(be64),
    .b2r_w_vld(wv64), .b2r_r_vld(rv64),
    .r2b_data(r2b_data), .r2b_rdy(r2b_rdy), .r2b_err(r2b_err));

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle32(input string tag);
    chk({tag, "_idle_wv"}, wv32, 0);
    chk({tag, "_idle_rv"}, rv32, 0);
    chk({tag, "_idle_rdy"}, ready32, 1);
    chk({tag, "_idle_resp"}, resp32, 0);
  endtask

  task automatic chk_err32(input string tag, input logic rdy);
    chk({tag, "_err_vld"}, {wv32, rv32}, 0);
    chk({tag, "_err_rdy"}, ready32, rdy);
    chk({tag, "_err_resp"}, resp32, 1);
  endtask

  task automatic chk_beat32(input string tag, input logic [31:0] a);
    chk({tag, "_wv"}, wv32, 1);
    chk({tag, "_addr"}, addr32, a);
    chk({tag, "_rdy"}, ready32, 1);
    chk({tag, "_resp"}, resp32, 0);
  endtask

  // Single NONSEQ transfer on the 32-bit bridge with zero-wait register side
  task automatic run_vec(input vec_t v, input string tag);
    sel32 = 1'b1; htrans = HTRANS_NONSEQ; haddr = v.addr; hwrite = v.write;
    hsize = v.size; hburst = HBURST_SINGLE; r2b_rdy = 1'b1; r2b_err = 1'b0;
    tick();
    htrans = HTRANS_IDLE; hwdata = {32'h0, v.wdata}; r2b_data = {32'h0, v.rdata};
    @(negedge clk);
    if (!v.err) begin
      chk({tag, "_wv"}, wv32, v.write);
      chk({tag, "_rv"}, rv32, !v.write);
      chk({tag, "_be"}, be32, v.be);
      chk({tag, "_addr"}, addr32, v.addr);
      chk({tag, "_rdy"}, ready32, 1);
      chk({tag, "_resp"}, resp32, 0);
      if (v.write) chk({tag, "_wdata"}, data32, v.wdata);
      else         chk({tag, "_rdata"}, rdata32, v.rdata);
    end else begin
      chk_err32({tag, "_e0"}, 1'b0);
      tick();
      @(negedge clk);
      chk_err32({tag, "_e1"}, 1'b1);
    end
    tick();
    @(negedge clk);
    chk_idle32(tag);
    tick();
  endtask

  initial begin
    vecs[0] = '{32'h10,  1'b1, 3'd2, 32'hDEADBEEF, 32'h0,        4'b1111, 1'b0};
    vecs[1] = '{32'h20,  1'b0, 3'd2, 32'h0,        32'hCAFEF00D, 4'b1111, 1'b0};
    vecs[2] = '{32'h13,  1'b1, 3'd0, 32'h000000A5, 32'h0,        4'b1000, 1'b0};
    vecs[3] = '{32'h2,   1'b0, 3'd1, 32'h0,        32'h0000BEEF, 4'b1100, 1'b0};
    vecs[4] = '{32'h2,   1'b1, 3'd2, 32'h11111111, 32'h0,        4'b0000, 1'b1};
    vecs[5] = '{32'h8,   1'b1, 3'd3, 32'h22222222, 32'h0,        4'b0000, 1'b1};
    vecs[6] = '{32'h5,   1'b0, 3'd1, 32'h0,        32'h0,        4'b0000, 1'b1};
    vecs[7] = '{32'h101, 1'b1, 3'd0, 32'h00005A00, 32'h0,        4'b0010, 1'b0};

    sel32 = 0; sel64 = 0; htrans = HTRANS_IDLE; haddr = 0; hwrite = 0; hsize = 0;
    hburst = 0; hwdata = 0; r2b_data = 0; r2b_rdy = 1; r2b_err = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle32("reset32");
    chk("reset64_rdy", ready64, 1);
    chk("reset64_vld", {wv64, rv64}, 0);
    chk("reset64_resp", resp64, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // 64-bit halfword read at byte 6
    sel32 = 0; sel64 = 1; htrans = HTRANS_NONSEQ; haddr = 32'h6; hwrite = 0;
    hsize = 3'd1; hburst = HBURST_SINGLE;
    tick();
    htrans = HTRANS_IDLE; r2b_data = 64'h1234;
    @(negedge clk);
    chk("w64_be", be64, 8'hC0);
    chk("w64_rv", rv64, 1);
    chk("w64_rdata", rdata64, 64'h1234);
    chk("w64_rdy", ready64, 1);
    chk("w64_resp", resp64, 0);
    tick();
    sel64 = 0;
    @(negedge clk);
    chk("w64_done", rv64, 0);
    tick();

    // WRAP4 burst 0x38,0x3C,(BUSY),0x30,0x34
    sel32 = 1; hburst = HBURST_WRAP4; hsize = 3'd2; hwrite = 1;
    htrans = HTRANS_NONSEQ; haddr = 32'h38;
    tick();
    htrans = HTRANS_SEQ; haddr = 32'h3C; hwdata = 64'h1;
    @(negedge clk);
    chk_beat32("wrap_b0", 32'h38);
    tick();
    htrans = HTRANS_BUSY; haddr = 32'h30; hwdata = 64'h2;
    @(negedge clk);
    chk_beat32("wrap_b1", 32'h3C);
    tick();
    htrans = HTRANS_SEQ; haddr = 32'h30;
    @(negedge clk);
    chk_idle32("wrap_busy");
    tick();
    htrans = HTRANS_SEQ; haddr = 32'h34; hwdata = 64'h3;
    @(negedge clk);
    chk_beat32("wrap_b2", 32'h30);
    tick();
    htrans = HTRANS_IDLE; hwdata = 64'h4;
    @(negedge clk);
    chk_beat32("wrap_b3", 32'h34);
    tick();
    @(negedge clk);
    chk_idle32("wrap_end");

    // WRAP4 with a bad third beat (0x40 instead of 0x30)
    tick();
    htrans = HTRANS_NONSEQ; haddr = 32'h38;
    tick();
    htrans = HTRANS_SEQ; haddr = 32'h3C;
    tick();
    htrans = HTRANS_SEQ; haddr = 32'h40;
    @(negedge clk);
    chk_beat32("wrapbad_b1", 32'h3C);
    tick();
    htrans = HTRANS_IDLE;
    @(negedge clk);
    chk_err32("wrapbad_e0", 1'b0);
    tick();
    @(negedge clk);
    chk_err32("wrapbad_e1", 1'b1);
    tick();
    @(negedge clk);
    chk_idle32("wrapbad_end");

    // Timeout: four wait cycles then ERROR
    tick();
    hburst = HBURST_SINGLE; htrans = HTRANS_NONSEQ; haddr = 32'h0; hwrite = 1; r2b_rdy = 0;
    tick();
    htrans = HTRANS_IDLE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d_wv", k), wv32, 1);
      chk($sformatf("to_wait%0d_rdy", k), ready32, 0);
      tick();
    end
    @(negedge clk);
    chk_err32("to_e0", 1'b0);
    tick();
    @(negedge clk);
    chk_err32("to_e1", 1'b1);
    tick();
    @(negedge clk);
    chk_idle32("to_end");
    r2b_rdy = 1;

    // Register-side error on a read
    tick();
    htrans = HTRANS_NONSEQ; haddr = 32'h44; hwrite = 0; r2b_err = 1;
    tick();
    htrans = HTRANS_IDLE;
    @(negedge clk);
    chk("rerr_rv", rv32, 1);
    chk("rerr_rdy", ready32, 0);
    chk("rerr_resp", resp32, 0);
    tick();
    r2b_err = 0;
    @(negedge clk);
    chk_err32("rerr_e0", 1'b0);
    tick();
    @(negedge clk);
    chk_err32("rerr_e1", 1'b1);

    // Asynchronous reset while the register side is stalling
    tick();
    htrans = HTRANS_NONSEQ; haddr = 32'h50; hwrite = 1; r2b_rdy = 0;
    tick();
    htrans = HTRANS_IDLE;
    @(negedge clk);
    chk("arst_pre_wv", wv32, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_idle32("arst");
    tick();
    tick();
    rst_n = 1'b1;
    r2b_rdy = 1;
    tick();
    run_vec(vecs[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/srdl2sv_ahblite_bridge.md
SRDL2SV_AHBLITE_BRIDGE -- requirements
Module: srdl2sv_ahblite_bridge

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register-bus and HWDATA/HRDATA width; legal values 32 or 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, HADDR and b2r_addr width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, maximum wait cycles per transfer; 0 disables timeout.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: HCLK  in  1  clock; HRESETn  in  1  async active-low reset.
REQ-005 The block SHALL have the following AHB slave inputs: HSEL in 1; HADDR in ADDR_W; HWRITE in 1; HSIZE in 3; HBURST in 3; HPROT in 4 (unused); HTRANS in 2; HWDATA in DATA_W; HREADY in 1; HMASTLOCK in 1 (unused).
REQ-006 The block SHALL have the following AHB slave outputs: HREADYOUT out 1; HRESP out 1; HRDATA out DATA_W.
REQ-007 The block SHALL have the following register-side outputs: b2r_addr out ADDR_W; b2r_data out DATA_W; b2r_byte_en out DATA_W/8; b2r_w_vld out 1; b2r_r_vld out 1.
REQ-008 The block SHALL have the following register-side inputs: r2b_data in DATA_W; r2b_rdy in 1; r2b_err in 1.

Function
REQ-009 Address phase SHALL be accepted only when HSEL & HREADY & HTRANS in {NONSEQ, SEQ}; HADDR, HWRITE, HSIZE and HBURST are captured at that edge.
REQ-010 IDLE/BUSY transfers, or HSEL low, SHALL get zero-wait OKAY and generate no b2r valid.
REQ-011 FSM states SHALL be ST_IDLE, ST_DATA, ST_ERR_0 and ST_ERR_1, reached as follows: accepted legal transfer -> ST_DATA; accepted illegal transfer -> ST_ERR_0.
REQ-012 In ST_DATA the block SHALL assert b2r_w_vld/b2r_r_vld per the captured HWRITE, drive b2r_data=HWDATA, and drive HREADYOUT=r2b_rdy.
REQ-013 In ST_DATA, when r2b_rdy & !r2b_err, the block SHALL return OKAY with HRDATA=r2b_data, then go to ST_DATA if a new transfer is accepted on the same edge, else ST_IDLE.
REQ-014 In ST_DATA, r2b_rdy & r2b_err SHALL go to ST_ERR_0.
REQ-015 ST_ERR_0 SHALL drive HREADYOUT=0, HRESP=1, go to ST_ERR_1 and issue no b2r valid.
REQ-016 ST_ERR_1 SHALL drive HREADYOUT=1, HRESP=1, go to ST_IDLE and ignore any address phase coincident with it.
REQ-017 An access SHALL be illegal if (a) 2^HSIZE > DATA_W/8, (b) HADDR is not aligned to 2^HSIZE, or (c) a SEQ address differs from the expected address.
REQ-018 The expected address SHALL be prev+2^HSIZE for INCR*, and the same increment wrapped within a (beats*2^HSIZE)-byte aligned boundary for WRAP4/8/16.
REQ-019 b2r_byte_en SHALL have 2^HSIZE consecutive ones starting at byte lane HADDR[log2(DATA_W/8)-1:0]; b2r_addr SHALL be the captured HADDR unmodified.
REQ-020 A wait counter SHALL count ST_DATA cycles with r2b_rdy=0; on reaching TIMEOUT the block SHALL drop the valid and go to ST_ERR_0; the counter clears on each new data phase.
REQ-021 A BUSY during a burst SHALL be OKAY, SHALL NOT advance the expected address, and SHALL NOT break burst address checking.
REQ-022 HTRANS/HADDR changes while HREADY=0 SHALL be ignored.

Reset
REQ-023 Asserting HRESETn low SHALL put the FSM in ST_IDLE, clear the wait counter and expected address, and force b2r_w_vld=b2r_r_vld=0, HREADYOUT=1, HRESP=0 immediately, including mid-transfer.
REQ-024 After reset the captured address/data registers SHALL have no required value.

Configuration
REQ-025 With SRDL2SV_AHB_B2R_FLOP_EN defined, b2r_* outputs SHALL be registered, adding one cycle; HREADYOUT is low for at least one cycle per transfer and r2b_* is sampled one cycle after the registered valid.
REQ-026 Without SRDL2SV_AHB_B2R_FLOP_EN, b2r_* SHALL be combinational from FSM state and captured address/control.

Structure
REQ-027 HTRANS_t, HBURST_t, HRESP_t and the FSM state enum SHALL live in shared package srdl2sv_ahb_pkg, together with a function returning burst beat count.
REQ-028 Expected-address and byte-enable generation SHALL be in sub-module srdl2sv_ahb_addr_gen; the FSM and counter SHALL stay in the top module.

Verification
REQ-029 DATA_W=32: NONSEQ write HADDR=0x10, HSIZE=2, HWDATA=0xDEADBEEF, r2b_rdy=1 -> b2r_w_vld for 1 cycle, byte_en=4'b1111, HRESP=0.
REQ-030 DATA_W=64: read HADDR=0x6, HSIZE=1 -> byte_en=8'b1100_0000; r2b_data=0x1234 returned on HRDATA.
REQ-031 WRAP4, HSIZE=2, start 0x38 -> beats 0x38, 0x3C, 0x30, 0x34 accepted; a SEQ to 0x40 instead of 0x30 -> two-cycle ERROR.
REQ-032 HADDR=0x2, HSIZE=2 -> no b2r valid; HREADYOUT 0 then 1 with HRESP=1 on both cycles.
REQ-033 TIMEOUT=4 with r2b_rdy held 0 -> valid for 4 cycles, then ERROR response, FSM returns to ST_IDLE.
REQ-034 HRESETn asserted mid-wait -> valids drop asynchronously; first post-reset NONSEQ completes OKAY.
